sprite_blitter: RTL
===================

# sprite_blitter

Positioned, scalable, animated sprite renderer for the VGA pipeline. It takes the pixel coordinates and produces a palette colour plus an opaque-pixel flag for one sprite. The sprite is placed at a latched screen position with power-of-two scaling, and animation frames are stored back-to-back in ROM. It sits between the VGA controller (DrawX/DrawY/blank) and the per-pixel colour mux, which selects background or sprite using `hit`.

## Interface
- `SPR_W`, 68, sprite width in texels
- `SPR_H`, 64, sprite height in texels
- `NUM_FRAMES`, 4, animation frames stored consecutively in ROM
- `ANIM_DIV`, 8, video frames per animation step (≥1)
- `PAL_BITS`, 4, palette index width
- `TRANSP_IDX`, 0, palette index treated as transparent
- `vga_clk`  in  1  pixel clock; all logic on posedge
- `reset_n`  in  1  synchronous, active-low reset
- `DrawX`, `DrawY`  in  10  current pixel coordinate
- `blank`  in  1  1 = active display region
- `frame_start`  in  1  one-cycle pulse per video frame, issued in vertical blanking
- `pos_x`, `pos_y`  in  10  sprite top-left corner on screen
- `scale_log2`  in  2  scale factor 1/2/4/8
- `visible`  in  1  sprite enable
- `anim_en`  in  1  1 = auto-advance frames; 0 = use `frame_sel`
- `frame_sel`  in  FRAME_W  static frame index, FRAME_W = max(1, $clog2(NUM_FRAMES))
- `flip_x`  in  1  horizontal mirror (see Configuration)
- `red`, `green`, `blue`  out  4  sprite colour; 0 when not hit
- `hit`  out  1  opaque sprite pixel at the delayed coordinate
- `cur_frame`  out  FRAME_W  frame currently being drawn

## Operation
- Shadow registers hold pos_x, pos_y, scale_log2, visible and flip_x. They load only on `frame_start`, so mid-frame input changes have no effect until the next pulse.
- In-box test uses 11-bit arithmetic with no wrap: `DrawX ≥ px && DrawX < px + (SPR_W<<s)`, with the same form for Y.
  - Any part of the box beyond 639/479 is simply clipped.
- Texel coordinates: u = (DrawX−px)>>s and v = (DrawY−py)>>s. If flip is active, u = SPR_W−1−u.
- ROM address = cur_frame·SPR_W·SPR_H + v·SPR_W + u, with ADDR_W = $clog2(NUM_FRAMES·SPR_W·SPR_H). No divider or multiplier by a non-constant is used.
- `hit` = delayed(blank & in_box & visible) & (rom_q ≠ TRANSP_IDX). When `hit`=0, colour outputs are 0.
- Animation with anim_en=1: each `frame_start` increments div_cnt. When div_cnt = ANIM_DIV−1, div_cnt wraps to 0 and cur_frame advances, wrapping from NUM_FRAMES−1 to 0.
- Animation with anim_en=0: each `frame_start` sets div_cnt to 0 and loads cur_frame from frame_sel. If frame_sel ≥ NUM_FRAMES, cur_frame loads 0.
- Reset (reset_n=0 at a posedge) values:
  - Colour, hit, cur_frame, div_cnt: all 0.
  - Shadow registers: all 0, so shadow visible = 0.
  - Pipeline valid bits: cleared.
- Reset asserted mid-line kills in-flight pixels. Outputs are 0 on the cycle after the reset edge.

## Timing
- Fixed latency of 3 cycles from DrawX/DrawY/blank to red/green/blue/hit. The consumer delays background coordinates to match.
  - Cycle 1 registers the address and the in-box/blank flags.
  - Cycle 2 produces the synchronous ROM output, with the flags delayed alongside it.
  - Cycle 3 registers the palette lookup and `hit`.
- Throughput is one pixel per clock with no stalls.
- If `frame_start` coincides with a pixel, that pixel uses the old shadow values. Shadow registers and cur_frame update on the same edge.
- ROM is clocked on the posedge of `vga_clk`; no negedge clocking.

## Configuration
- `SPRITE_FLIP_EN` defined: `flip_x` is latched into the shadow registers and mirrors u.
- Not defined: `flip_x` is ignored and no mirror logic is generated. The port remains, so the instantiation is identical.

## Structure
- Package `sprite_pkg` holds:
  - the `rgb444_t` struct for {red, green, blue};
  - the scale encoding constants;
  - a function `frame_w(n)` returning max(1, $clog2(n)).
- Sub-module `sprite_rom`: parametrised depth/width, synchronous registered read, contents from a memory init file.
- The palette is an inline case on the index. Each sprite asset provides its own palette include.

## Test plan
- Reset then frame_start with visible=0: hit=0 and colour 0 over a full frame. cur_frame=0.
- pos=(100,50), scale_log2=0, frame_sel=0, anim_en=0: DrawX/Y=(100,50) yields hit with the ROM address-0 colour 3 cycles later. (99,50) and (168,50) yield hit=0.
- scale_log2=1: pixels (100,50), (101,51) and (101,50) all map to address 0. (236,50) yields hit=0, and (235,50) reads u=67.
- anim_en=1, ANIM_DIV=8, NUM_FRAMES=4: cur_frame reads 1 after the 8th frame_start and 0 after the 32nd.
- Change pos_x mid-frame: output is unchanged until the next frame_start. Assert reset_n=0 mid-line: outputs are 0 and cur_frame=0 on the next cycle.
- With SPRITE_FLIP_EN and flip_x=1: pixel (100,50) reads address 67. Without the macro it reads address 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, scale codes and helpers for the sprite blitter
package sprite_pkg;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb444_t;

  localparam logic [1:0] SCALE_X1 = 2'd0;
  localparam logic [1:0] SCALE_X2 = 2'd1;
  localparam logic [1:0] SCALE_X4 = 2'd2;
  localparam logic [1:0] SCALE_X8 = 2'd3;

  function automatic int frame_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Texel image of the current sprite asset, indexed by linear ROM address.
  function automatic logic [7:0] sprite_image(input int addr);
    return 8'((addr & 15) + ((addr >> 4) & 15) + 3 * ((addr >> 8) & 15) +
              ((addr >> 12) & 7) + 5);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - synchronous-read texel ROM holding all animation frames
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH  = 17408,
  parameter int WIDTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  q
);

  always_ff @(posedge clk) begin
    q <= (int'(addr) < DEPTH) ? WIDTH'(sprite_image(int'(addr))) : '0;
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - positioned, scaled, animated sprite renderer, 3-cycle pixel pipeline
// Define SPRITE_FLIP_EN to latch flip_x and mirror the sprite horizontally.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 68,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int PAL_BITS   = 4,
  parameter int TRANSP_IDX = 0,
  localparam int FRAME_W   = frame_w(NUM_FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic [1:0]         scale_log2,
  input  logic               visible,
  input  logic               anim_en,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               flip_x,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               hit,
  output logic [FRAME_W-1:0] cur_frame
);

  localparam int FRAME_SIZE = SPR_W * SPR_H;
  localparam int DEPTH      = NUM_FRAMES * FRAME_SIZE;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int U_W        = frame_w(SPR_W);
  localparam int V_W        = frame_w(SPR_H);
  localparam int DIV_W      = frame_w(ANIM_DIV);

  logic [9:0]          sh_px, sh_py;
  logic [1:0]          sh_scale;
  logic                sh_vis;
  logic [DIV_W-1:0]    div_cnt;
  logic [10:0]         px, py, span_x, span_y, dx, dy;
  logic                in_box;
  logic [U_W-1:0]      u_raw, u;
  logic [V_W-1:0]      v;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic                vld1, vld2, opaque;
  logic [PAL_BITS-1:0] rom_q;
  rgb444_t             pal_rgb, colour_q;

  // Shadow registers and animation state all move together on frame_start.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sh_px     <= '0;
      sh_py     <= '0;
      sh_scale  <= '0;
      sh_vis    <= 1'b0;
      div_cnt   <= '0;
      cur_frame <= '0;
    end else if (frame_start) begin
      sh_px    <= pos_x;
      sh_py    <= pos_y;
      sh_scale <= scale_log2;
      sh_vis   <= visible;
      if (anim_en) begin
        if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
          div_cnt   <= '0;
          cur_frame <= (cur_frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : cur_frame + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt   <= '0;
        cur_frame <= ({1'b0, frame_sel} < (FRAME_W + 1)'(NUM_FRAMES)) ? frame_sel : '0;
      end
    end
  end

  always_comb begin
    span_x = 11'(SPR_W);
    span_y = 11'(SPR_H);
    case (sh_scale)
      SCALE_X1: ;
      SCALE_X2: begin span_x = 11'(SPR_W) << 1; span_y = 11'(SPR_H) << 1; end
      SCALE_X4: begin span_x = 11'(SPR_W) << 2; span_y = 11'(SPR_H) << 2; end
      SCALE_X8: begin span_x = 11'(SPR_W) << 3; span_y = 11'(SPR_H) << 3; end
    endcase
  end

  // 11-bit compare so a box hanging past the right/bottom edge clips instead of wrapping.
  assign px     = {1'b0, sh_px};
  assign py     = {1'b0, sh_py};
  assign dx     = {1'b0, DrawX} - px;
  assign dy     = {1'b0, DrawY} - py;
  assign in_box = ({1'b0, DrawX} >= px) && ({1'b0, DrawX} < px + span_x) &&
                  ({1'b0, DrawY} >= py) && ({1'b0, DrawY} < py + span_y);
  assign u_raw  = U_W'(dx >> sh_scale);
  assign v      = V_W'(dy >> sh_scale);

`ifdef SPRITE_FLIP_EN
  logic sh_flip;

  always_ff @(posedge vga_clk) begin
    if (!reset_n)         sh_flip <= 1'b0;
    else if (frame_start) sh_flip <= flip_x;
  end

  assign u = sh_flip ? U_W'(SPR_W - 1) - u_raw : u_raw;
`else
  logic unused_flip;
  assign unused_flip = flip_x;
  assign u           = u_raw;
`endif

  assign addr_d = ADDR_W'(cur_frame) * ADDR_W'(FRAME_SIZE) +
                  ADDR_W'(v) * ADDR_W'(SPR_W) + ADDR_W'(u);

  sprite_rom #(
    .DEPTH (DEPTH),
    .WIDTH (PAL_BITS),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk (vga_clk),
    .addr(addr_q),
    .q   (rom_q)
  );

  always_comb begin
    pal_rgb = '0;
    case (int'(rom_q))
      1:  pal_rgb = 12'hF00;
      2:  pal_rgb = 12'h0F0;
      3:  pal_rgb = 12'h00F;
      4:  pal_rgb = 12'hFF0;
      5:  pal_rgb = 12'h0FF;
      6:  pal_rgb = 12'hF0F;
      7:  pal_rgb = 12'hFFF;
      8:  pal_rgb = 12'h800;
      9:  pal_rgb = 12'h080;
      10: pal_rgb = 12'h008;
      11: pal_rgb = 12'h880;
      12: pal_rgb = 12'h088;
      13: pal_rgb = 12'h808;
      14: pal_rgb = 12'h888;
      15: pal_rgb = 12'h421;
      default: pal_rgb = '0;
    endcase
  end

  assign opaque = vld2 && (rom_q != PAL_BITS'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      vld1     <= 1'b0;
      vld2     <= 1'b0;
      hit      <= 1'b0;
      colour_q <= '0;
    end else begin
      addr_q   <= addr_d;
      vld1     <= blank & in_box & sh_vis;
      vld2     <= vld1;
      hit      <= opaque;
      colour_q <= opaque ? pal_rgb : '0;
    end
  end

  assign red   = colour_q.red;
  assign green = colour_q.green;
  assign blue  = colour_q.blue;

endmodule
